tug_referee: RTL and testbench

- Upstream game-logic stage of the tug-of-war datapath. It turns the two player push-buttons into rope movement on the 7-LED bar.
- Produces the 7-bit `score` LED pattern and the `wingame` event consumed by the victory-cheer stage.
- Provides input synchronisation, press edge detection, anti-mash lockout, rope position tracking, win detection and the game state machine.

---
 rtl/tug_pkg.sv | 43 ++++
 rtl/pb_edge.sv | 31 +++
 rtl/tug_referee.sv | 116 +++++++++++
 tb/tb_tug_referee.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/tug_pkg.sv
// Shared definitions for the tug-of-war datapath: game states, LED patterns
// and the rope-position-to-LED mapping used by the referee and the cheer stage.
package tug_pkg;

   typedef enum logic [1:0] {
      PLAY  = 2'd0,
      LOCK  = 2'd1,
      WIN_R = 2'd2,
      WIN_L = 2'd3
   } tugState_e;

   localparam logic [6:0] SCORE_CENTER = 7'b0001000;
   localparam logic [6:0] SCORE_WIN_R  = 7'b0000111;
   localparam logic [6:0] SCORE_WIN_L  = 7'b1110000;
   localparam int         POS_MAX      = 3;

   // Rope position k lights bit (3-k); negative positions light toward the left end.
   function automatic logic [6:0] posToScore(input logic signed [2:0] pos);
      logic [6:0] pattern;
      case ($unsigned(pos))
         3'b001:  pattern = 7'b0000100;
         3'b010:  pattern = 7'b0000010;
         3'b011:  pattern = 7'b0000001;
         3'b111:  pattern = 7'b0010000;
         3'b110:  pattern = 7'b0100000;
         3'b101:  pattern = 7'b1000000;
         default: pattern = SCORE_CENTER;
      endcase
      return pattern;
   endfunction

   function automatic logic [6:0] stateToScore(input tugState_e state,
                                               input logic signed [2:0] pos);
      logic [6:0] pattern;
      case (state)
         WIN_R:   pattern = SCORE_WIN_R;
         WIN_L:   pattern = SCORE_WIN_L;
         default: pattern = posToScore(pos);
      endcase
      return pattern;
   endfunction

endpackage

// File: rtl/pb_edge.sv
// Two-flop synchroniser for a raw push-button followed by a registered
// rising-edge detector; a held button yields exactly one press pulse.
module pb_edge (
   input  logic clk,
   input  logic rst,
   input  logic pb,
   output logic press
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;
   logic press_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= pb;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         press_q <= sync2_q & ~prev_q;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/tug_referee.sv
// Tug-of-war referee: turns synchronised button presses into rope moves,
// enforces the anti-mash lockout and detects the win at either end of the bar.
module tug_referee
   import tug_pkg::*;
#(
   parameter int LOCKOUT = 4,
   parameter int POS_MAX = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pbl,
   input  logic       pbr,
   output logic [6:0] score,
   output logic       wingame,
   output logic       winner
);

   if (LOCKOUT < 0 || LOCKOUT > 15) begin : gBadLockout
      $error("tug_referee: LOCKOUT must be within 0..15");
   end
   if (POS_MAX != 3) begin : gBadPosMax
      $error("tug_referee: the 7-LED bar requires POS_MAX = 3");
   end

   localparam logic signed [2:0] PosHi   = 3'(POS_MAX);
   localparam logic signed [2:0] PosLo   = -3'(POS_MAX);
   localparam logic [3:0]        LockVal = 4'(LOCKOUT);

   logic pressL;
   logic pressR;

   pb_edge uEdgeL (.clk(clk), .rst(rst), .pb(pbl), .press(pressL));
   pb_edge uEdgeR (.clk(clk), .rst(rst), .pb(pbr), .press(pressR));

   tugState_e         state_q, state_d;
   logic signed [2:0] pos_q, pos_d;
   logic [3:0]        lockCnt_q, lockCnt_d;
   logic [6:0]        score_q, score_d;
   logic              wingame_q, wingame_d;
   logic              winner_q, winner_d;

   // Simultaneous presses cancel; win states only leave through reset.
   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      lockCnt_d = lockCnt_q;
      wingame_d = 1'b0;
      winner_d  = winner_q;
      case (state_q)
         PLAY: begin
            if (pressR && !pressL) begin
               if (pos_q == PosHi) begin
                  state_d   = WIN_R;
                  wingame_d = 1'b1;
                  winner_d  = 1'b1;
               end else begin
                  pos_d = pos_q + 3'sd1;
                  if (LOCKOUT != 0) begin
                     state_d   = LOCK;
                     lockCnt_d = LockVal;
                  end
               end
            end else if (pressL && !pressR) begin
               if (pos_q == PosLo) begin
                  state_d   = WIN_L;
                  wingame_d = 1'b1;
                  winner_d  = 1'b0;
               end else begin
                  pos_d = pos_q - 3'sd1;
                  if (LOCKOUT != 0) begin
                     state_d   = LOCK;
                     lockCnt_d = LockVal;
                  end
               end
            end
         end
         LOCK: begin
            if (lockCnt_q <= 4'd1) begin
               state_d   = PLAY;
               lockCnt_d = 4'd0;
            end else begin
               lockCnt_d = lockCnt_q - 4'd1;
            end
         end
         default: ;
      endcase
   end

   // The LED pattern trails the position/state by one registered cycle.
   always_comb begin
      score_d = stateToScore(state_q, pos_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= PLAY;
         pos_q     <= 3'sd0;
         lockCnt_q <= 4'd0;
         score_q   <= SCORE_CENTER;
         wingame_q <= 1'b0;
         winner_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         lockCnt_q <= lockCnt_d;
         score_q   <= score_d;
         wingame_q <= wingame_d;
         winner_q  <= winner_d;
      end
   end

   assign score   = score_q;
   assign wingame = wingame_q;
   assign winner  = winner_q;

endmodule

// File: tb/tb_tug_referee.sv
// Self-checking bench for tug_referee: expected LED/winner/win-count results
// are queued as each button press is driven and compared once play settles.
module tb_tug_referee;

   logic       clk;
   logic       rst;
   logic       pbl;
   logic       pbr;
   logic [6:0] score;
   logic       wingame;
   logic       winner;

   int total;
   int bad;
   int winCount;
   int winRun;
   int maxWinRun;

   string      tagQ[$];
   logic [6:0] scoreQ[$];
   logic       winnerQ[$];
   int         winsQ[$];

   tug_referee #(.LOCKOUT(4), .POS_MAX(3)) dut (
      .clk(clk),
      .rst(rst),
      .pbl(pbl),
      .pbr(pbr),
      .score(score),
      .wingame(wingame),
      .winner(winner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts wingame pulses and the longest run of consecutive high cycles.
   initial begin
      winCount  = 0;
      winRun    = 0;
      maxWinRun = 0;
      forever begin
         @(negedge clk);
         if (wingame === 1'b1) begin
            winCount++;
            winRun++;
            if (winRun > maxWinRun) maxWinRun = winRun;
         end else begin
            winRun = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Raises the chosen buttons for two cycles and queues the expected outcome.
   task automatic applyStimulus(input string tag, input logic l, input logic r,
                                input logic [6:0] expScore, input logic expWinner,
                                input int expWins);
      @(negedge clk);
      pbl = l;
      pbr = r;
      repeat (2) @(negedge clk);
      pbl = 1'b0;
      pbr = 1'b0;
      tagQ.push_back(tag);
      scoreQ.push_back(expScore);
      winnerQ.push_back(expWinner);
      winsQ.push_back(expWins);
   endtask

   task automatic drainScoreboard(input int settle);
      string tag;
      repeat (settle) @(negedge clk);
      while (tagQ.size() > 0) begin
         tag = tagQ.pop_front();
         checkOutput({tag, "_score"}, 32'(score), 32'(scoreQ.pop_front()));
         checkOutput({tag, "_winner"}, 32'(winner), 32'(winnerQ.pop_front()));
         checkOutput({tag, "_wins"}, 32'(winCount), 32'(winsQ.pop_front()));
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      pbl   = 1'b0;
      pbr   = 1'b0;

      // Reset state and idle
      #1;
      checkOutput("rst_score", 32'(score), 32'h08);
      checkOutput("rst_wingame", 32'(wingame), 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("idle_score", 32'(score), 32'h08);
         checkOutput("idle_wingame", 32'(wingame), 32'h0);
         checkOutput("idle_winner", 32'(winner), 32'h0);
      end

      // Lockout drops a press arriving mid-lock
      applyStimulus("lock_first", 1'b0, 1'b1, 7'b0000100, 1'b0, 0);
      applyStimulus("lock_dropped", 1'b0, 1'b1, 7'b0000100, 1'b0, 0);
      drainScoreboard(12);
      applyStimulus("lock_after", 1'b0, 1'b1, 7'b0000010, 1'b0, 0);
      drainScoreboard(12);

      // Simultaneous presses cancel, then play continues from PLAY
      doReset();
      applyStimulus("both", 1'b1, 1'b1, 7'b0001000, 1'b0, 0);
      drainScoreboard(12);
      applyStimulus("both_then_r", 1'b0, 1'b1, 7'b0000100, 1'b0, 0);
      drainScoreboard(12);

      // Right player walks the rope to the end and wins
      doReset();
      applyStimulus("r1", 1'b0, 1'b1, 7'b0000100, 1'b0, 0);
      drainScoreboard(12);
      applyStimulus("r2", 1'b0, 1'b1, 7'b0000010, 1'b0, 0);
      drainScoreboard(12);
      applyStimulus("r3", 1'b0, 1'b1, 7'b0000001, 1'b0, 0);
      drainScoreboard(12);
      applyStimulus("r_win", 1'b0, 1'b1, 7'b0000111, 1'b1, 1);
      drainScoreboard(12);
      applyStimulus("r_after_l", 1'b1, 1'b0, 7'b0000111, 1'b1, 1);
      drainScoreboard(12);
      applyStimulus("r_after_r", 1'b0, 1'b1, 7'b0000111, 1'b1, 1);
      drainScoreboard(12);

      // Mirror: left player wins
      doReset();
      applyStimulus("l1", 1'b1, 1'b0, 7'b0010000, 1'b0, 1);
      drainScoreboard(12);
      applyStimulus("l2", 1'b1, 1'b0, 7'b0100000, 1'b0, 1);
      drainScoreboard(12);
      applyStimulus("l3", 1'b1, 1'b0, 7'b1000000, 1'b0, 1);
      drainScoreboard(12);
      applyStimulus("l_win", 1'b1, 1'b0, 7'b1110000, 1'b0, 2);
      drainScoreboard(12);
      applyStimulus("l_after", 1'b1, 1'b0, 7'b1110000, 1'b0, 2);
      drainScoreboard(12);

      // Asynchronous reset in the middle of a lockout at +2
      doReset();
      applyStimulus("a1", 1'b0, 1'b1, 7'b0000100, 1'b0, 2);
      drainScoreboard(12);
      @(negedge clk);
      pbr = 1'b1;
      repeat (2) @(negedge clk);
      pbr = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      checkOutput("async_pre_score", 32'(score), 32'h02);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("async_score", 32'(score), 32'h08);
      checkOutput("async_wingame", 32'(wingame), 32'h0);
      checkOutput("async_winner", 32'(winner), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      applyStimulus("a_resume", 1'b0, 1'b1, 7'b0000100, 1'b0, 2);
      drainScoreboard(12);

      checkOutput("wingame_width", 32'(maxWinRun), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
